mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL run on one clock, `clk`, and SHALL use an asynchronous, active-low reset, `rst_n`.
REQ-002 Parameter: WIDTH, default 64, data width of each requester and of the output.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: a_valid  input  1  requester A offers a_data.
REQ-006 Port: a_data  input  WIDTH  requester A payload.
REQ-007 Port: a_ready  output  1  requester A beat accepted this cycle.
REQ-008 Port: b_valid  input  1  requester B offers b_data.
REQ-009 Port: b_data  input  WIDTH  requester B payload.
REQ-010 Port: b_ready  output  1  requester B beat accepted this cycle.
REQ-011 Port: out_valid  output  1  out_data holds a beat.
REQ-012 Port: out_data  output  WIDTH  registered selected payload.
REQ-013 Port: out_sel  output  1  source of out_data (0=A, 1=B).
REQ-014 Port: out_ready  input  1  consumer takes the beat.

Function
REQ-015 The block SHALL implement a two-state FSM, EMPTY and FULL; FULL exactly when out_valid=1.
REQ-016 Accept window SHALL be open when state==EMPTY or (FULL and out_ready=1).
REQ-017 Grant: with the window open and exactly one valid, that requester SHALL be granted.
REQ-018 With both valid and the window open, the requester not granted last SHALL be granted (round-robin).
REQ-019 a_ready/b_ready SHALL be combinational, one-hot-or-zero, and asserted only for the granted requester.
REQ-020 Transfer on a side SHALL occur when valid&ready; next cycle out_data=its data, out_sel=its id, out_valid=1, last_grant=its id.
REQ-021 Latency SHALL be one cycle from accept to out_valid.
REQ-022 Throughput SHALL be one beat per cycle when out_ready=1 continuously (drain and refill same cycle).
REQ-023 In FULL with out_ready=0, out_data/out_sel SHALL be held stable, and both readies SHALL be 0.
REQ-024 In FULL with out_ready=1 and no valid requester, the FSM SHALL go to EMPTY and out_valid SHALL be 0 next cycle.
REQ-025 A requester holding valid SHALL receive a grant within 2 accept windows (no starvation).
REQ-026 Input changes while valid&!ready SHALL be ignored; no data SHALL be captured without a handshake.

Reset
REQ-027 While rst_n=0: state=EMPTY, out_valid=0, out_data=0, out_sel=0, last_grant=B (so A wins the first tie), and a_ready=b_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard any held beat immediately; it SHALL NOT be replayed after release.

Configuration
REQ-029 Macro MUX_ARBITER_STATS_EN SHALL add two ports: a_cnt and b_cnt, each output, 16 bits, saturating count of accepted beats per requester.
REQ-030 With MUX_ARBITER_STATS_EN, a counter SHALL increment on its handshake, hold at 16'hFFFF, and clear on reset.
REQ-031 Without MUX_ARBITER_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package mux_arbiter_pkg SHALL hold: the state enum (EMPTY, FULL), the requester-id typedef (REQ_A=0, REQ_B=1), and the default-width constant 64.
REQ-033 Sub-module mux_arbiter_rr SHALL be the combinational 2-way round-robin pick (inputs: valids, last_grant, window; output: grant vector).
REQ-034 Data selection SHALL be a 2:1 mux driven by the grant, feeding the output register.

Verification
REQ-035 Single requester: a_valid=1, a_data=64'h123456789ABCDEF0, out_ready=1 -> a_ready=1 the same cycle; next cycle out_valid=1, out_data=64'h123456789ABCDEF0, out_sel=0.
REQ-036 Tie after reset: both valid, b_data=64'hFFFFFFFFFFFFFFFF, out_ready=1 for 4 cycles -> outputs alternate A,B,A,B, one beat per cycle, out_sel=0,1,0,1.
REQ-037 Backpressure: FULL with A beat, out_ready=0 for 3 cycles, b_valid=1 -> out_data stable, b_ready=0 throughout; out_ready=1 -> B accepted that cycle, B beat appears next cycle.
REQ-038 Drain: FULL, out_ready=1, no valids -> out_valid=0 next cycle, state EMPTY.
REQ-039 Reset mid-op: FULL with 64'hFFFFFFFFFFFFFFFF, rst_n=0 asynchronously -> out_valid=0 and out_data=0 before the next clk edge; after release with a tie, A wins.
REQ-040 With MUX_ARBITER_STATS_EN: 70000 continuous A beats -> a_cnt=16'hFFFF (saturated), b_cnt=0.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// Contents: FSM state enum, requester-id enum, default data width, stats counter width.
package mux_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage : mux_arbiter_pkg

// File: rtl/mux_arbiter_rr.sv
// Combinational 2-way round-robin pick.
// Ports:
//   valid_i      [1:0] request valids (bit 0 = A, bit 1 = B)
//   last_grant_i       requester granted most recently
//   window_i           accept window open
//   grant_o      [1:0] one-hot-or-zero grant (purely combinational)
module mux_arbiter_rr
  import mux_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_e    last_grant_i,
  input  logic       window_i,
  output logic [1:0] grant_o
);

  // On a tie, favour whichever side did not win last time.
  always_comb begin
    grant_o = 2'b00;
    if (window_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_grant_i == REQ_B) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule : mux_arbiter_rr

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter feeding a single registered output slot.
// Optional feature macro: MUX_ARBITER_STATS_EN adds saturating per-requester
// accepted-beat counters a_cnt / b_cnt.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   a_valid/a_data      requester A offer;  a_ready accepted this cycle (comb)
//   b_valid/b_data      requester B offer;  b_ready accepted this cycle (comb)
//   out_valid/out_data  registered output beat; out_sel source id (0=A, 1=B)
//   out_ready           consumer takes the beat
//   a_cnt/b_cnt         (MUX_ARBITER_STATS_EN only) accepted beat counts
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
`ifdef MUX_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
`endif
);

  state_e           state_q, state_d;
  req_id_e          last_grant_q, last_grant_d;
  req_id_e          out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             window_c;
  logic [1:0]       grant_c;
  req_id_e          grant_id_c;
  logic [WIDTH-1:0] sel_data_c;

  // Window gated by rst_n so readies stay low while reset is held.
  assign window_c = rst_n & ((state_q == EMPTY) | out_ready);

  mux_arbiter_rr u_rr (
    .valid_i      ({b_valid, a_valid}),
    .last_grant_i (last_grant_q),
    .window_i     (window_c),
    .grant_o      (grant_c)
  );

  assign a_ready    = grant_c[0];
  assign b_ready    = grant_c[1];
  assign grant_id_c = grant_c[1] ? REQ_B : REQ_A;

  // 2:1 payload mux feeding the output register.
  assign sel_data_c = grant_c[1] ? b_data : a_data;

  // Next-state: a grant always implies a handshake, refilling the slot;
  // otherwise a consumed beat empties it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_sel_d    = out_sel_q;
    out_data_d   = out_data_q;
    if (|grant_c) begin
      state_d      = FULL;
      last_grant_d = grant_id_c;
      out_sel_d    = grant_id_c;
      out_data_d   = sel_data_c;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= REQ_B;
      out_sel_q    <= REQ_A;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_sel_q    <= out_sel_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

`ifdef MUX_ARBITER_STATS_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  // Saturating accepted-beat counters.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (a_valid && a_ready && (a_cnt_q != {CNT_W{1'b1}})) a_cnt_d = a_cnt_q + CNT_W'(1);
    if (b_valid && b_ready && (b_cnt_q != {CNT_W{1'b1}})) b_cnt_d = b_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`endif

endmodule : mux_arbiter

// File: tb/tb_mux_arbiter.sv
// Directed, table-driven bench for mux_arbiter (WIDTH=64).
module tb_mux_arbiter;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, out_sel;
  logic [W-1:0] out_data;
`ifdef MUX_ARBITER_STATS_EN
  logic [15:0]  a_cnt, b_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_ARBITER_STATS_EN
    ,
    .a_cnt     (a_cnt),
    .b_cnt     (b_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs for the current cycle plus the outputs expected during that cycle
  // (readies are combinational, out_* reflect the previous edge).
  typedef struct {
    logic         av;
    logic [W-1:0] ad;
    logic         bv;
    logic [W-1:0] bd;
    logic         ordy;
    logic         ea;
    logic         eb;
    logic         ev;
    logic [W-1:0] ed;
    logic         es;
  } vec_t;

  localparam logic [W-1:0] A1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [W-1:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] B2 = 64'hCAFE_BABE_DEAD_BEEF;
  localparam logic [W-1:0] C5 = 64'h5555_5555_5555_5555;
  localparam logic [W-1:0] A3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [W-1:0] CA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [W-1:0] Z  = 64'h0;

  vec_t vecs[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Tie after reset: alternate A,B,A,B then drain.
    vecs[0]  = '{1'b1, A1, 1'b1, FF, 1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0};
    vecs[1]  = '{1'b1, A1, 1'b1, FF, 1'b1, 1'b0, 1'b1, 1'b1, A1, 1'b0};
    vecs[2]  = '{1'b1, A1, 1'b1, FF, 1'b1, 1'b1, 1'b0, 1'b1, FF, 1'b1};
    vecs[3]  = '{1'b1, A1, 1'b1, FF, 1'b1, 1'b0, 1'b1, 1'b1, A1, 1'b0};
    vecs[4]  = '{1'b0, Z,  1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b1, FF, 1'b1};
    vecs[5]  = '{1'b0, Z,  1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b0, Z,  1'b0};
    // Single requester A.
    vecs[6]  = '{1'b1, A1, 1'b0, Z,  1'b1, 1'b1, 1'b0, 1'b0, Z,  1'b0};
    // Backpressure with B offering changing junk until the handshake.
    vecs[7]  = '{1'b0, Z,  1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0, 1'b1, A1, 1'b0};
    vecs[8]  = '{1'b0, Z,  1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b0, 1'b0, 1'b1, A1, 1'b0};
    vecs[9]  = '{1'b0, Z,  1'b1, 64'h3333_3333_3333_3333, 1'b0, 1'b0, 1'b0, 1'b1, A1, 1'b0};
    vecs[10] = '{1'b0, Z,  1'b1, B2, 1'b1, 1'b0, 1'b1, 1'b1, A1, 1'b0};
    vecs[11] = '{1'b0, Z,  1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b1, B2, 1'b1};
    vecs[12] = '{1'b0, Z,  1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0};
    // EMPTY accepts regardless of out_ready; round-robin under backpressure.
    vecs[13] = '{1'b0, Z,  1'b1, C5, 1'b0, 1'b0, 1'b1, 1'b0, Z,  1'b0};
    vecs[14] = '{1'b1, A3, 1'b1, CA, 1'b0, 1'b0, 1'b0, 1'b1, C5, 1'b1};
    vecs[15] = '{1'b1, A3, 1'b1, CA, 1'b1, 1'b1, 1'b0, 1'b1, C5, 1'b1};
    vecs[16] = '{1'b0, Z,  1'b1, CA, 1'b1, 1'b0, 1'b1, 1'b1, A3, 1'b0};
    vecs[17] = '{1'b0, Z,  1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b1, CA, 1'b1};
    vecs[18] = '{1'b0, Z,  1'b0, Z,  1'b1, 1'b0, 1'b0, 1'b1, CA, 1'b1};
    vecs[19] = '{1'b0, Z,  1'b0, Z,  1'b0, 1'b0, 1'b0, 1'b0, Z,  1'b0};

    // Reset state, with requests present to prove readies stay low.
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = A1;
    b_valid = 1'b1; b_data = FF;
    out_ready = 1'b1;
    step();
    step();
    chk("rst out_valid", W'(out_valid), W'(0));
    chk("rst out_data",  out_data,       Z);
    chk("rst out_sel",   W'(out_sel),   W'(0));
    chk("rst a_ready",   W'(a_ready),   W'(0));
    chk("rst b_ready",   W'(b_ready),   W'(0));
`ifdef MUX_ARBITER_STATS_EN
    chk("rst a_cnt", W'(a_cnt), W'(0));
    chk("rst b_cnt", W'(b_cnt), W'(0));
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      a_valid   = vecs[i].av;
      a_data    = vecs[i].ad;
      b_valid   = vecs[i].bv;
      b_data    = vecs[i].bd;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d a_ready", i),   W'(a_ready),   W'(vecs[i].ea));
      chk($sformatf("vec%0d b_ready", i),   W'(b_ready),   W'(vecs[i].eb));
      chk($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d out_data", i), out_data,     vecs[i].ed);
        chk($sformatf("vec%0d out_sel", i),  W'(out_sel), W'(vecs[i].es));
      end
      step();
    end

    // Mid-operation async reset discards the held beat; A wins the tie after.
    a_valid = 1'b0; b_valid = 1'b1; b_data = FF; out_ready = 1'b0;
    step();
    b_valid = 1'b0;
    #1;
    chk("mid full out_valid", W'(out_valid), W'(1));
    chk("mid full out_data",  out_data,       FF);
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = A3; b_valid = 1'b1; b_data = CA; out_ready = 1'b1;
    #1;
    chk("async rst out_valid", W'(out_valid), W'(0));
    chk("async rst out_data",  out_data,       Z);
    chk("async rst a_ready",   W'(a_ready),   W'(0));
    chk("async rst b_ready",   W'(b_ready),   W'(0));
    step();
    chk("held rst out_valid", W'(out_valid), W'(0));
    rst_n = 1'b1;
    #1;
    chk("post rst a_ready", W'(a_ready), W'(1));
    chk("post rst b_ready", W'(b_ready), W'(0));
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("post rst out_valid", W'(out_valid), W'(1));
    chk("post rst out_data",  out_data,       A3);
    chk("post rst out_sel",   W'(out_sel),   W'(0));
    step();

`ifdef MUX_ARBITER_STATS_EN
    // Saturation: 70000 back-to-back A beats.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = A1; b_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    a_valid = 1'b0;
    #1;
    chk("sat a_cnt", W'(a_cnt), W'(16'hFFFF));
    chk("sat b_cnt", W'(b_cnt), W'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_arbiter
